// File: rtl/demux_4.sv
// demux_4: 1-to-4 router with a one-word holding register and per-output delivery counters
module demux_4 #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enb,
    input  logic [DATA_WIDTH-1:0] entrada_demux,
    input  logic                  valido_entrada,
    input  logic [1:0]            selector_demux,
    input  logic [3:0]            lleno_salida,
    output logic                  listo_entrada,
    output logic [DATA_WIDTH-1:0] salida0_demux,
    output logic [DATA_WIDTH-1:0] salida1_demux,
    output logic [DATA_WIDTH-1:0] salida2_demux,
    output logic [DATA_WIDTH-1:0] salida3_demux,
    output logic [3:0]            push_salida,
    output logic [CNT_WIDTH-1:0]  cuenta0_salida,
    output logic [CNT_WIDTH-1:0]  cuenta1_salida,
    output logic [CNT_WIDTH-1:0]  cuenta2_salida,
    output logic [CNT_WIDTH-1:0]  cuenta3_salida
);
    typedef enum logic {VACIO, LLENO} estado_t;
    estado_t               estado;
    logic [DATA_WIDTH-1:0] dato_reg;
    logic [1:0]            sel_reg;
    logic [CNT_WIDTH-1:0]  cuenta [4];
    logic                  ocupado, activo, acepta;
    assign ocupado = estado == LLENO;
    // reset masks the outputs so they already show the cleared state during the reset cycle
    assign activo        = enb && !reset && ocupado;
    assign push_salida   = activo ? ~lleno_salida & (4'b0001 << sel_reg) : 4'b0000;
    assign listo_entrada = enb && (reset || !ocupado || |push_salida);
    assign acepta        = valido_entrada && listo_entrada;
    assign salida0_demux = (activo && sel_reg == 2'd0) ? dato_reg : '0;
    assign salida1_demux = (activo && sel_reg == 2'd1) ? dato_reg : '0;
    assign salida2_demux = (activo && sel_reg == 2'd2) ? dato_reg : '0;
    assign salida3_demux = (activo && sel_reg == 2'd3) ? dato_reg : '0;
    assign cuenta0_salida = cuenta[0];
    assign cuenta1_salida = cuenta[1];
    assign cuenta2_salida = cuenta[2];
    assign cuenta3_salida = cuenta[3];
    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= VACIO;
            dato_reg <= '0;
            sel_reg  <= '0;
            for (int i = 0; i < 4; i++) cuenta[i] <= '0;
        end else if (enb) begin
            if (acepta) begin
                dato_reg <= entrada_demux;
                sel_reg  <= selector_demux;
                estado   <= LLENO;
            end else if (|push_salida) begin
                estado <= VACIO;
            end
            for (int i = 0; i < 4; i++)
                if (push_salida[i]) cuenta[i] <= cuenta[i] + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_demux_4.sv
// tb_demux_4: directed vector table, hand sequences and random traffic against a queue-based model
module tb_demux_4;
    logic       clk = 1'b0;
    logic       reset, enb, valido_entrada;
    logic [3:0] entrada_demux, lleno_salida;
    logic [1:0] selector_demux;
    logic       listo_entrada;
    logic [3:0] salida0_demux, salida1_demux, salida2_demux, salida3_demux, push_salida;
    logic [3:0] cuenta0_salida, cuenta1_salida, cuenta2_salida, cuenta3_salida;
    int n_cmp = 0, n_err = 0;

    demux_4 dut (
        .clk(clk), .reset(reset), .enb(enb), .entrada_demux(entrada_demux),
        .valido_entrada(valido_entrada), .selector_demux(selector_demux),
        .lleno_salida(lleno_salida), .listo_entrada(listo_entrada),
        .salida0_demux(salida0_demux), .salida1_demux(salida1_demux),
        .salida2_demux(salida2_demux), .salida3_demux(salida3_demux),
        .push_salida(push_salida),
        .cuenta0_salida(cuenta0_salida), .cuenta1_salida(cuenta1_salida),
        .cuenta2_salida(cuenta2_salida), .cuenta3_salida(cuenta3_salida)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
    } word_t;
    word_t      q[$];
    int         cnt[4];
    logic       m_listo;
    logic [3:0] m_push;
    logic [3:0] m_sal[4];

    typedef struct {
        logic        r, e, v;
        logic [1:0]  s;
        logic [3:0]  d, f;
        logic        el;
        logic [3:0]  ep;
        logic [15:0] es, ec;
    } vec_t;
    vec_t tbl[20];

    function automatic logic [15:0] sal_all();
        return {salida3_demux, salida2_demux, salida1_demux, salida0_demux};
    endfunction
    function automatic logic [15:0] cnt_all();
        return {cuenta3_salida, cuenta2_salida, cuenta1_salida, cuenta0_salida};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // drive on the falling edge, then predict and compare the combinational outputs
    task automatic drive(input logic r, e, v, input logic [1:0] s, input logic [3:0] d, f);
        @(negedge clk);
        reset = r; enb = e; valido_entrada = v; selector_demux = s;
        entrada_demux = d; lleno_salida = f;
        #1;
        m_push = '0; m_listo = 1'b0;
        for (int i = 0; i < 4; i++) m_sal[i] = '0;
        if (r) m_listo = e;
        else if (e) begin
            if (q.size() == 0) m_listo = 1'b1;
            else begin
                m_sal[q[0].s] = q[0].d;
                m_listo = !f[q[0].s];
                if (!f[q[0].s]) m_push[q[0].s] = 1'b1;
            end
        end
        chk("model_listo", 32'(listo_entrada), 32'(m_listo));
        chk("model_push", 32'(push_salida), 32'(m_push));
        chk("model_sal", 32'(sal_all()), 32'({m_sal[3], m_sal[2], m_sal[1], m_sal[0]}));
        chk("model_cnt", 32'(cnt_all()),
            32'({4'(cnt[3]), 4'(cnt[2]), 4'(cnt[1]), 4'(cnt[0])}));
        chk("push_onehot", 32'($onehot0(push_salida)), 32'd1);
    endtask

    task automatic tick();
        if (reset) begin
            q.delete();
            for (int i = 0; i < 4; i++) cnt[i] = 0;
        end else if (enb) begin
            if (|m_push) begin
                cnt[q[0].s] = (cnt[q[0].s] + 1) % 16;
                void'(q.pop_front());
            end
            if (valido_entrada && m_listo) q.push_back('{d: entrada_demux, s: selector_demux});
        end
        @(posedge clk);
    endtask

    task automatic cyc(input logic r, e, v, input logic [1:0] s, input logic [3:0] d, f);
        drive(r, e, v, s, d, f);
        tick();
    endtask

    initial begin
        //          r  e  v  s  d     f        listo push     sal       cnt
        tbl[0]  = '{1, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 1, 1, 2, 4'hA, 4'b0000, 1, 4'b0000, 16'h0000, 16'h0000};
        tbl[2]  = '{0, 1, 1, 0, 4'h1, 4'b0000, 1, 4'b0100, 16'h0A00, 16'h0000};
        tbl[3]  = '{0, 1, 1, 1, 4'h2, 4'b0000, 1, 4'b0001, 16'h0001, 16'h0100};
        tbl[4]  = '{0, 1, 1, 2, 4'h3, 4'b0000, 1, 4'b0010, 16'h0020, 16'h0101};
        tbl[5]  = '{0, 1, 1, 3, 4'h4, 4'b0000, 1, 4'b0100, 16'h0300, 16'h0111};
        tbl[6]  = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b1000, 16'h4000, 16'h0211};
        tbl[7]  = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000, 16'h1211};
        tbl[8]  = '{0, 1, 1, 1, 4'h5, 4'b0010, 1, 4'b0000, 16'h0000, 16'h1211};
        tbl[9]  = '{0, 1, 1, 0, 4'h6, 4'b0010, 0, 4'b0000, 16'h0050, 16'h1211};
        tbl[10] = '{0, 1, 1, 0, 4'h6, 4'b0010, 0, 4'b0000, 16'h0050, 16'h1211};
        tbl[11] = '{0, 1, 1, 0, 4'h6, 4'b0010, 0, 4'b0000, 16'h0050, 16'h1211};
        tbl[12] = '{0, 1, 1, 0, 4'h6, 4'b0000, 1, 4'b0010, 16'h0050, 16'h1211};
        tbl[13] = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b0001, 16'h0006, 16'h1221};
        tbl[14] = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000, 16'h1222};
        tbl[15] = '{0, 1, 1, 3, 4'h7, 4'b0000, 1, 4'b0000, 16'h0000, 16'h1222};
        tbl[16] = '{0, 0, 1, 0, 4'h8, 4'b0000, 0, 4'b0000, 16'h0000, 16'h1222};
        tbl[17] = '{0, 0, 1, 0, 4'h8, 4'b0000, 0, 4'b0000, 16'h0000, 16'h1222};
        tbl[18] = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b1000, 16'h7000, 16'h1222};
        tbl[19] = '{0, 1, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000, 16'h2222};
        reset = 1'b1; enb = 1'b1; valido_entrada = 1'b0; selector_demux = '0;
        entrada_demux = '0; lleno_salida = '0;
        @(posedge clk);
        @(posedge clk);
        q.delete();
        for (int i = 0; i < 4; i++) cnt[i] = 0;

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].f);
            chk($sformatf("vec%0d_listo", i), 32'(listo_entrada), 32'(tbl[i].el));
            chk($sformatf("vec%0d_push", i), 32'(push_salida), 32'(tbl[i].ep));
            chk($sformatf("vec%0d_sal", i), 32'(sal_all()), 32'(tbl[i].es));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt_all()), 32'(tbl[i].ec));
            tick();
        end

        // 16 back-to-back words to output 3 wrap its counter back to 0
        cyc(1, 1, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 16; k++) cyc(0, 1, 1, 3, 4'(k), 4'h0);
        cyc(0, 1, 0, 0, 4'h0, 4'h0);
        drive(0, 1, 0, 0, 4'h0, 4'h0);
        chk("wrap_cnt3", 32'(cuenta3_salida), 32'd0);
        chk("wrap_others", 32'({cuenta2_salida, cuenta1_salida, cuenta0_salida}), 32'd0);
        tick();

        // a word stuck on a full destination is discarded by reset
        cyc(0, 1, 1, 1, 4'h9, 4'b0010);
        drive(0, 1, 1, 0, 4'h3, 4'b0010);
        chk("stuck_listo", 32'(listo_entrada), 32'd0);
        chk("stuck_sal1", 32'(salida1_demux), 32'h9);
        tick();
        drive(1, 1, 0, 0, 4'h0, 4'b0010);
        chk("rst_listo", 32'(listo_entrada), 32'd1);
        chk("rst_push", 32'(push_salida), 32'd0);
        tick();
        drive(0, 1, 0, 0, 4'h0, 4'b0000);
        chk("post_rst_listo", 32'(listo_entrada), 32'd1);
        chk("post_rst_push", 32'(push_salida), 32'd0);
        chk("post_rst_cnt", 32'(cnt_all()), 32'd0);
        tick();

        for (int k = 0; k < 3000; k++)
            cyc(($urandom % 64) == 0, ($urandom % 8) != 0, 1'($urandom),
                2'($urandom), 4'($urandom),
                ($urandom % 3) == 0 ? 4'($urandom) : 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
